// File: rtl/mem_port_arbiter.sv
// Arbiter for one shared single-port memory: instruction fetch (I, read-only) versus MEM stage (D).
// Grants one transaction at a time, with fetch anti-starvation and a per-transaction watchdog.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [2:0]            d_funct3,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  d_err,
  output logic                  stall_if,
  output logic                  stall_mem,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);
  localparam logic [7:0] WDOG_LAST   = 8'(TIMEOUT - 1);
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  state_e                state_q, state_d;
  logic [3:0]            i_wait_q, i_wait_d;
  logic [7:0]            wdog_q, wdog_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]            mem_funct3_q, mem_funct3_d;

  logic busy_i_s, busy_d_s, busy_s;
  logic done_s, expire_s, decide_s;
  logic i_elig_s, d_elig_s, grant_i_s, grant_d_s;

  // State decode.
  always_comb begin
    busy_i_s = 1'b0;
    busy_d_s = 1'b0;
    case (state_q)
      BUSY_I:  busy_i_s = 1'b1;
      BUSY_D:  busy_d_s = 1'b1;
      default: begin
        busy_i_s = 1'b0;
        busy_d_s = 1'b0;
      end
    endcase
  end

  assign busy_s   = busy_i_s | busy_d_s;
  assign done_s   = busy_s & mem_ready;
  // Ready in the expiry cycle takes precedence over the abort.
  assign expire_s = busy_s & ~mem_ready & (wdog_q == WDOG_LAST);
  assign decide_s = ~busy_s | done_s;

  // The completing port's request is stale this cycle, so it sits out the decision.
  assign i_elig_s  = i_req & ~(busy_i_s & mem_ready);
  assign d_elig_s  = d_req & ~(busy_d_s & mem_ready);
  assign grant_i_s = decide_s & i_elig_s & (~d_elig_s | (i_wait_q == STARVE_MAX));
  assign grant_d_s = decide_s & d_elig_s & ~grant_i_s;

  // Next-state, starvation counter, watchdog and command latch.
  always_comb begin
    state_d      = state_q;
    i_wait_d     = i_wait_q;
    wdog_d       = wdog_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_funct3_d = mem_funct3_q;
    if (grant_i_s) begin
      state_d      = BUSY_I;
      i_wait_d     = 4'd0;
      wdog_d       = 8'd0;
      mem_we_d     = 1'b0;
      mem_addr_d   = i_addr;
      mem_wdata_d  = {DATA_WIDTH{1'b0}};
      mem_funct3_d = FUNCT3_WORD;
    end else if (grant_d_s) begin
      state_d      = BUSY_D;
      wdog_d       = 8'd0;
      mem_we_d     = d_we;
      mem_addr_d   = d_addr;
      mem_wdata_d  = d_wdata;
      mem_funct3_d = d_funct3;
      if (i_elig_s && (i_wait_q != 4'hF)) begin
        i_wait_d = i_wait_q + 4'd1;
      end else begin
        i_wait_d = i_wait_q;
      end
    end else if (decide_s || expire_s) begin
      state_d = IDLE;
    end else if (busy_s) begin
      wdog_d = wdog_q + 8'd1;
    end else begin
      wdog_d = wdog_q;
    end
  end

  // State and command registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      i_wait_q     <= 4'd0;
      wdog_q       <= 8'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q  <= {DATA_WIDTH{1'b0}};
      mem_funct3_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      i_wait_q     <= i_wait_d;
      wdog_q       <= wdog_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
    end
  end

  assign mem_req    = busy_s;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_funct3 = mem_funct3_q;

  assign i_ready = busy_i_s & mem_ready;
  assign d_ready = busy_d_s & mem_ready;
  assign i_err   = busy_i_s & expire_s;
  assign d_err   = busy_d_s & expire_s;
  assign i_rdata = i_ready ? mem_rdata : {DATA_WIDTH{1'b0}};
  assign d_rdata = d_ready ? mem_rdata : {DATA_WIDTH{1'b0}};

  assign stall_if  = i_req & ~i_ready & ~i_err;
  assign stall_mem = d_req & ~d_ready & ~d_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant order, latency, starvation, watchdog and reset.
module tb_mem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int TO = 64;

  logic          clk;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready, i_err;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [2:0]    d_funct3;
  logic [DW-1:0] d_rdata;
  logic          d_ready, d_err;
  logic          stall_if, stall_mem;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  int vectors;
  int miscompares;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_funct3 = 3'b000; mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) tick();
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req: got %b exp 0", mem_req); end
    vectors++; if ({mem_we, mem_addr, mem_wdata, mem_funct3} !== '0) begin miscompares++;
      $display("FAIL rst_mem_fields: we=%b addr=%h wdata=%h f3=%b exp all 0", mem_we, mem_addr, mem_wdata, mem_funct3); end
    vectors++; if ({i_ready, d_ready, i_err, d_err} !== 4'b0000) begin miscompares++;
      $display("FAIL rst_pulses: got %b exp 0000", {i_ready, d_ready, i_err, d_err}); end
    i_req = 1'b1; d_req = 1'b1; #1;
    vectors++; if ({stall_if, stall_mem} !== 2'b11) begin miscompares++;
      $display("FAIL rst_stalls: got %b exp 11", {stall_if, stall_mem}); end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_i_only();
    i_req = 1'b1; i_addr = 9'h010;
    tick();
    vectors++; if ({mem_req, mem_we, mem_funct3} !== 5'b1_0_010) begin miscompares++;
      $display("FAIL io_grant: req/we/f3=%b exp 10010", {mem_req, mem_we, mem_funct3}); end
    vectors++; if (mem_addr !== 9'h010 || mem_wdata !== 32'h0) begin miscompares++;
      $display("FAIL io_addr: addr=%h wdata=%h exp 010/0", mem_addr, mem_wdata); end
    vectors++; if ({i_ready, stall_if} !== 2'b01) begin miscompares++;
      $display("FAIL io_wait: ready/stall=%b exp 01", {i_ready, stall_if}); end
    mem_ready = 1'b1; mem_rdata = 32'h00500093; #1;
    vectors++; if (i_ready !== 1'b1 || i_rdata !== 32'h00500093) begin miscompares++;
      $display("FAIL io_ready: ready=%b rdata=%h exp 1/00500093", i_ready, i_rdata); end
    vectors++; if (d_rdata !== 32'h0 || stall_if !== 1'b0 || d_ready !== 1'b0) begin miscompares++;
      $display("FAIL io_other: d_rdata=%h stall_if=%b d_ready=%b exp 0/0/0", d_rdata, stall_if, d_ready); end
    tick();
    mem_ready = 1'b0; mem_rdata = '0; i_addr = 9'h014; #1;
    vectors++; if ({mem_req, stall_if} !== 2'b01) begin miscompares++;
      $display("FAIL io_bubble: req/stall=%b exp 01", {mem_req, stall_if}); end
    tick();
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 9'h014) begin miscompares++;
      $display("FAIL io_regrant: req=%b addr=%h exp 1/014", mem_req, mem_addr); end
    mem_ready = 1'b1;
    tick();
    i_req = 1'b0; mem_ready = 1'b0; #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL io_idle: got %b exp 0", mem_req); end
  endtask

  task automatic test_back_to_back();
    i_req = 1'b1; i_addr = 9'h020;
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h040; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
    tick();
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 9'h040 || mem_wdata !== 32'hDEADBEEF) begin miscompares++;
      $display("FAIL b2b_d_first: we=%b addr=%h wdata=%h exp 1/040/deadbeef", mem_we, mem_addr, mem_wdata); end
    vectors++; if ({stall_if, stall_mem} !== 2'b11) begin miscompares++;
      $display("FAIL b2b_stalls: got %b exp 11", {stall_if, stall_mem}); end
    mem_ready = 1'b1; mem_rdata = 32'h12345678; #1;
    vectors++; if ({d_ready, i_ready, stall_mem} !== 3'b100 || i_rdata !== 32'h0) begin miscompares++;
      $display("FAIL b2b_d_done: d_rdy/i_rdy/stall=%b i_rdata=%h exp 100/0", {d_ready, i_ready, stall_mem}, i_rdata); end
    tick();
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0; #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 9'h020 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin miscompares++;
      $display("FAIL b2b_i_next: req=%b addr=%h we=%b wdata=%h exp 1/020/0/0", mem_req, mem_addr, mem_we, mem_wdata); end
    mem_ready = 1'b1; mem_rdata = 32'h0000A0B0; #1;
    vectors++; if (i_ready !== 1'b1 || i_rdata !== 32'h0000A0B0) begin miscompares++;
      $display("FAIL b2b_i_done: ready=%b rdata=%h exp 1/0000a0b0", i_ready, i_rdata); end
    tick();
    i_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_starvation_watchdog();
    int  cyc;
    bit  seen;
    i_req = 1'b1; i_addr = 9'h030;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h050;
    tick();
    for (int r = 0; r < SL; r++) begin
      vectors++; if (mem_addr !== 9'h050 || mem_req !== 1'b1) begin miscompares++;
        $display("FAIL starve_d_wins_%0d: addr=%h req=%b exp 050/1", r, mem_addr, mem_req); end
      seen = 1'b0;
      cyc = 1;
      while (!seen && cyc <= TO + 4) begin
        if (d_err === 1'b1) seen = 1'b1;
        else begin tick(); cyc++; end
      end
      vectors++; if (!seen || cyc != TO) begin miscompares++;
        $display("FAIL wdog_err_cycle_%0d: seen=%b cycle=%0d exp 1/%0d", r, seen, cyc, TO); end
      vectors++; if ({stall_mem, i_err, d_ready} !== 3'b000) begin miscompares++;
        $display("FAIL wdog_err_side_%0d: stall/i_err/d_rdy=%b exp 000", r, {stall_mem, i_err, d_ready}); end
      tick();
      mem_ready = 1'b1; #1;
      vectors++; if ({mem_req, d_ready, d_err} !== 3'b000) begin miscompares++;
        $display("FAIL wdog_idle_%0d: req/rdy/err=%b exp 000", r, {mem_req, d_ready, d_err}); end
      mem_ready = 1'b0;
      tick();
    end
    vectors++; if (mem_addr !== 9'h030 || mem_we !== 1'b0) begin miscompares++;
      $display("FAIL starve_i_wins: addr=%h we=%b exp 030/0", mem_addr, mem_we); end
    vectors++; if (dut.i_wait_q !== 4'd0) begin miscompares++;
      $display("FAIL starve_wait_clear: got %0d exp 0", dut.i_wait_q); end
    mem_ready = 1'b1; mem_rdata = 32'h00000013; #1;
    vectors++; if (i_ready !== 1'b1 || i_rdata !== 32'h00000013) begin miscompares++;
      $display("FAIL starve_i_done: ready=%b rdata=%h exp 1/00000013", i_ready, i_rdata); end
    tick();
    i_req = 1'b0; mem_ready = 1'b0; #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 9'h050 || dut.i_wait_q !== 4'd0) begin miscompares++;
      $display("FAIL starve_d_after: req=%b addr=%h wait=%0d exp 1/050/0", mem_req, mem_addr, dut.i_wait_q); end
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0001; #1;
    vectors++; if (d_ready !== 1'b1 || d_rdata !== 32'hCAFE0001) begin miscompares++;
      $display("FAIL starve_d_done: ready=%b rdata=%h exp 1/cafe0001", d_ready, d_rdata); end
    tick();
    d_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0; #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL starve_end_idle: got %b exp 0", mem_req); end
  endtask

  task automatic test_ready_at_expiry();
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h060; d_wdata = 32'hA5A5A5A5; d_funct3 = 3'b001;
    tick();
    vectors++; if (mem_funct3 !== 3'b001 || mem_addr !== 9'h060) begin miscompares++;
      $display("FAIL exp_grant: f3=%b addr=%h exp 001/060", mem_funct3, mem_addr); end
    repeat (TO - 1) tick();
    vectors++; if (d_err !== 1'b1) begin miscompares++; $display("FAIL exp_err_due: got %b exp 1", d_err); end
    mem_ready = 1'b1; mem_rdata = 32'h0; #1;
    vectors++; if ({d_ready, d_err} !== 2'b10) begin miscompares++;
      $display("FAIL exp_ready_wins: rdy/err=%b exp 10", {d_ready, d_err}); end
    tick();
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0; #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL exp_idle: got %b exp 0", mem_req); end
  endtask

  task automatic test_reset_midflight();
    i_req = 1'b1; i_addr = 9'h044;
    tick();
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL mid_grant: got %b exp 1", mem_req); end
    mem_ready = 1'b1; mem_rdata = 32'h11112222; rst = 1'b0; #1;
    vectors++; if ({mem_req, i_ready, i_err} !== 3'b000 || mem_addr !== 9'h000) begin miscompares++;
      $display("FAIL mid_drop: req/rdy/err=%b addr=%h exp 000/000", {mem_req, i_ready, i_err}, mem_addr); end
    mem_ready = 1'b0;
    tick();
    rst = 1'b1; #1;
    vectors++; if (mem_req !== 1'b0 || stall_if !== 1'b1) begin miscompares++;
      $display("FAIL mid_release: req=%b stall_if=%b exp 0/1", mem_req, stall_if); end
    tick();
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 9'h044) begin miscompares++;
      $display("FAIL mid_regrant: req=%b addr=%h exp 1/044", mem_req, mem_addr); end
    mem_ready = 1'b1; #1;
    vectors++; if (i_ready !== 1'b1 || i_rdata !== 32'h11112222) begin miscompares++;
      $display("FAIL mid_done: ready=%b rdata=%h exp 1/11112222", i_ready, i_rdata); end
    tick();
    i_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_i_only();
    test_back_to_back();
    test_starvation_watchdog();
    test_ready_at_expiry();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
